// File: rtl/ibus_byte_master.sv
// IBUS initiator: splits one CPU byte/word/long access into big-endian single-byte IBUS
// transfers for 8-bit peripherals, with alignment checking and a wait-state timeout.
module ibus_byte_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DI,
    input  logic [1:0]  CPU_SZ,
    input  logic        CPU_WE,
    input  logic        CPU_REQ,
    output logic        CPU_BUSY,
    output logic        CPU_DONE,
    output logic        CPU_ERR,
    output logic [31:0] CPU_DO,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  sz_q, sz_d;
    logic [1:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [7:0]  tmo_q, tmo_d;

    logic [1:0]  last_idx;
    logic [31:0] cur_addr;
    logic [1:0]  lane;
    logic [1:0]  pos;
    logic [7:0]  wr_byte;
    logic [7:0]  rd_byte;
    logic [8:0]  tmo_inc;
    logic        req_bad;

    // Byte idx of an N-byte access sits at result position N-1-idx (big-endian).
    always_comb begin
        case (sz_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
        cur_addr = addr_q + {30'd0, idx_q};
        lane     = cur_addr[1:0];
        pos      = last_idx - idx_q;
        wr_byte  = wdata_q[{pos, 3'b000} +: 8];
        case (lane)
            2'd0:    rd_byte = IBUS_DI[31:24];
            2'd1:    rd_byte = IBUS_DI[23:16];
            2'd2:    rd_byte = IBUS_DI[15:8];
            default: rd_byte = IBUS_DI[7:0];
        endcase
        tmo_inc = {1'b0, tmo_q} + 9'd1;
        req_bad = (CPU_SZ == 2'b11) ||
                  ((CPU_SZ == 2'b01) && CPU_A[0]) ||
                  ((CPU_SZ == 2'b10) && (CPU_A[1:0] != 2'b00));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sz_q    <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            sz_q    <= sz_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sz_d    = sz_q;
        idx_d   = idx_q;
        we_d    = we_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        if (CE_R) begin
            case (state_q)
                StIdle: begin
                    if (CPU_REQ) begin
                        addr_d  = CPU_A;
                        wdata_d = CPU_DI;
                        sz_d    = CPU_SZ;
                        we_d    = CPU_WE;
                        idx_d   = 2'd0;
                        tmo_d   = 8'd0;
                        rdata_d = 32'd0;
                        err_d   = req_bad;
                        state_d = req_bad ? StDone : StXfer;
                    end
                end
                StXfer: begin
                    if (!IBUS_BUSY) begin
                        tmo_d = 8'd0;
                        if (!we_q) begin
                            rdata_d[{pos, 3'b000} +: 8] = rd_byte;
                        end
                        if (idx_q == last_idx) begin
                            err_d   = 1'b0;
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        tmo_d = tmo_inc[7:0];
                        if (tmo_inc == 9'(TIMEOUT)) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    idx_d   = 2'd0;
                    tmo_d   = 8'd0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs depend only on registered state, so they change only after a clock edge.
    always_comb begin
        CPU_BUSY = (state_q != StIdle);
        CPU_DONE = 1'b0;
        CPU_ERR  = 1'b0;
        CPU_DO   = 32'd0;
        IBUS_A   = 32'd0;
        IBUS_DO  = 32'd0;
        IBUS_BA  = 4'd0;
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b0;
        case (state_q)
            StXfer: begin
                IBUS_REQ = 1'b1;
                IBUS_A   = cur_addr;
                IBUS_WE  = we_q;
                IBUS_BA  = 4'b1000 >> lane;
                if (we_q) begin
                    IBUS_DO = {wr_byte, 24'd0} >> {lane, 3'b000};
                end
            end
            StDone: begin
                CPU_DONE = 1'b1;
                CPU_ERR  = err_q;
                CPU_DO   = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ibus_byte_master.sv
// Self-checking bench for ibus_byte_master: table of accesses against a byte-wide slave
// model with a scoreboard, plus hand sequences for cycle detail, CE_R hold and reset abort.
module tb_ibus_byte_master;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst, ce_r;
    logic [31:0] cpu_a, cpu_di;
    logic [1:0]  cpu_sz;
    logic        cpu_we, cpu_req;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_do;
    logic [31:0] ibus_a, ibus_do, ibus_di;
    logic [3:0]  ibus_ba;
    logic        ibus_we, ibus_req, ibus_busy;

    ibus_byte_master #(.TIMEOUT(TMO)) dut (
        .CLK(clk), .RST(rst), .CE_R(ce_r),
        .CPU_A(cpu_a), .CPU_DI(cpu_di), .CPU_SZ(cpu_sz), .CPU_WE(cpu_we), .CPU_REQ(cpu_req),
        .CPU_BUSY(cpu_busy), .CPU_DONE(cpu_done), .CPU_ERR(cpu_err), .CPU_DO(cpu_do),
        .IBUS_A(ibus_a), .IBUS_DO(ibus_do), .IBUS_DI(ibus_di), .IBUS_BA(ibus_ba),
        .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req), .IBUS_BUSY(ibus_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] di;
        logic [1:0]  sz;
        logic        we;
        int          stall_byte;
        int          stall_len;
        logic        err;
        logic [31:0] dout;
        int          lat;
        int          acc;
        int          reqc;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          lat;
        int          acc;
        int          reqc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];

    // Slave model: 256-byte memory, other lanes driven with 0xEE to catch lane mix-ups.
    logic [7:0] mem [256];
    int acc_cnt, stall_seen;
    int stall_byte = -1;
    int stall_len  = 0;

    function automatic logic [31:0] lane_word(input logic [7:0] b, input logic [1:0] l);
        case (l)
            2'd0:    return {b, 24'hEEEEEE};
            2'd1:    return {8'hEE, b, 16'hEEEE};
            2'd2:    return {16'hEEEE, b, 8'hEE};
            default: return {24'hEEEEEE, b};
        endcase
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign ibus_di   = lane_word(mem[ibus_a[7:0]], ibus_a[1:0]);
    assign ibus_busy = ibus_req && (acc_cnt == stall_byte) && (stall_seen < stall_len);

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i[7:0] ^ 8'h5A;
        mem[8'h10] = 8'h11;
        mem[8'h11] = 8'h22;
        mem[8'h12] = 8'hAB;
        mem[8'h13] = 8'hCD;
        acc_cnt    = 0;
        stall_seen = 0;
        forever begin
            @(posedge clk);
            if (ce_r) begin
                if (!ibus_req) begin
                    acc_cnt    <= 0;
                    stall_seen <= 0;
                end else if (ibus_busy) begin
                    stall_seen <= stall_seen + 1;
                end else begin
                    acc_cnt    <= acc_cnt + 1;
                    stall_seen <= 0;
                    if (ibus_we) mem[ibus_a[7:0]] <= lane_byte(ibus_do, ibus_a[1:0]);
                end
            end
        end
    end

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   reqc_tot = 0;
    int   reqc_base = 0;
    int   done_cnt = 0;
    logic done_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One cycle: sample at the falling edge, score any new CPU_DONE against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (ibus_req) reqc_tot++;
        if (cpu_done && !done_last) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = sb.pop_front();
                chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                chk("cpu_do", cpu_do, e.dout);
                chk("latency", cyc - start_cyc - 1, e.lat);
                chk("accepts", acc_cnt, e.acc);
                chk("req_cycles", reqc_tot - reqc_base, e.reqc);
            end
        end
        done_last = cpu_done;
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] di, input logic [1:0] sz,
                         input logic we, input bit push, input exp_t e);
        cpu_a     = a;
        cpu_di    = di;
        cpu_sz    = sz;
        cpu_we    = we;
        cpu_req   = 1'b1;
        start_cyc = cyc;
        reqc_base = reqc_tot;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_a   = $urandom;
        cpu_di  = $urandom;
        cpu_sz  = 2'($urandom_range(0, 3));
        cpu_we  = 1'($urandom_range(0, 1));
        tick();
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int d0 = done_cnt;
        exp_t e = '{v.err, v.dout, v.lat, v.acc, v.reqc};
        stall_byte = v.stall_byte;
        stall_len  = v.stall_len;
        issue(v.a, v.di, v.sz, v.we, 1'b1, e);
        wait_done(d0);
        stall_byte = -1;
        stall_len  = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {27'd0, cpu_busy, cpu_done, cpu_err, ibus_req, ibus_we}, 32'd0);
        chk({tag, "_cpu_do"}, cpu_do, 32'd0);
        chk({tag, "_ibus_a"}, ibus_a, 32'd0);
        chk({tag, "_ibus_do"}, ibus_do, 32'd0);
        chk({tag, "_ibus_ba"}, {28'd0, ibus_ba}, 32'd0);
    endtask

    initial begin
        int   d0;
        exp_t e;

        //         addr          di            sz    we    stb stl err   dout        lat acc reqc
        vecs[0]  = '{32'hFFFFFE12, 32'h0,        2'd1, 1'b0, -1, 0, 1'b0, 32'h0000ABCD, 2, 2, 2};
        vecs[1]  = '{32'hFFFFFE12, 32'h00001234, 2'd1, 1'b1, -1, 0, 1'b0, 32'h0,        2, 2, 2};
        vecs[2]  = '{32'hFFFFFE12, 32'h0,        2'd1, 1'b0, -1, 0, 1'b0, 32'h00001234, 2, 2, 2};
        vecs[3]  = '{32'hFFFFFE10, 32'h0,        2'd2, 1'b0,  2, 3, 1'b0, 32'h11221234, 7, 4, 7};
        vecs[4]  = '{32'hFFFFFE11, 32'h0,        2'd1, 1'b0, -1, 0, 1'b1, 32'h0,        0, 0, 0};
        vecs[5]  = '{32'hFFFFFE10, 32'h0,        2'd3, 1'b0, -1, 0, 1'b1, 32'h0,        0, 0, 0};
        vecs[6]  = '{32'hFFFFFE12, 32'h55667788, 2'd2, 1'b1, -1, 0, 1'b1, 32'h0,        0, 0, 0};
        vecs[7]  = '{32'hFFFFFE13, 32'h0,        2'd0, 1'b0, -1, 0, 1'b0, 32'h00000034, 1, 1, 1};
        vecs[8]  = '{32'hFFFFFE01, 32'hFFFFFF5A, 2'd0, 1'b1, -1, 0, 1'b0, 32'h0,        1, 1, 1};
        vecs[9]  = '{32'hFFFFFE01, 32'h0,        2'd0, 1'b0, -1, 0, 1'b0, 32'h0000005A, 1, 1, 1};
        vecs[10] = '{32'hFFFFFE20, 32'hDEADBEEF, 2'd2, 1'b1, -1, 0, 1'b0, 32'h0,        4, 4, 4};
        vecs[11] = '{32'hFFFFFE20, 32'h0,        2'd2, 1'b0, -1, 0, 1'b0, 32'hDEADBEEF, 4, 4, 4};
        vecs[12] = '{32'hFFFFFE22, 32'h0,        2'd1, 1'b0, -1, 0, 1'b0, 32'h0000BEEF, 2, 2, 2};
        vecs[13] = '{32'hFFFFFE1F, 32'h0,        2'd0, 1'b0,  0, 10, 1'b1, 32'h0,       4, 0, 4};
        vecs[14] = '{32'hFFFFFE10, 32'h0,        2'd2, 1'b0,  2, 10, 1'b1, 32'h11220000, 6, 2, 6};
        vecs[15] = '{32'hFFFFFE10, 32'h0,        2'd2, 1'b0,  3, 3, 1'b0, 32'h11221234, 7, 4, 7};
        vecs[16] = '{32'hFFFFFE12, 32'h0,        2'd1, 1'b0,  1, 4, 1'b1, 32'h00001200, 5, 1, 5};

        rst = 1'b1;
        ce_r = 1'b1;
        cpu_a = '0;
        cpu_di = '0;
        cpu_sz = '0;
        cpu_we = 1'b0;
        cpu_req = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("idle");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Cycle-level word write; a stray request during the access must be ignored.
        d0 = done_cnt;
        e = '{1'b0, 32'h0, 2, 2, 2};
        issue(32'hFFFFFE12, 32'h00001234, 2'd1, 1'b1, 1'b1, e);
        chk("w0_ibus_a", ibus_a, 32'hFFFFFE12);
        chk("w0_ibus_ba", {28'd0, ibus_ba}, 32'h2);
        chk("w0_ibus_do", ibus_do, 32'h00001200);
        chk("w0_we_req", {30'd0, ibus_we, ibus_req}, 32'h3);
        cpu_req = 1'b1;
        cpu_sz  = 2'b11;
        tick();
        cpu_req = 1'b0;
        chk("w1_ibus_a", ibus_a, 32'hFFFFFE13);
        chk("w1_ibus_ba", {28'd0, ibus_ba}, 32'h1);
        chk("w1_ibus_do", ibus_do, 32'h00000034);
        wait_done(d0);
        run_vec('{32'hFFFFFE12, 32'h0, 2'd1, 1'b0, -1, 0, 1'b0, 32'h00001234, 2, 2, 2});

        // CE_R low for 5 cycles after byte 0 of a long read: nothing may move.
        d0 = done_cnt;
        e = '{1'b0, 32'h11221234, 9, 4, 9};
        issue(32'hFFFFFE10, 32'h0, 2'd2, 1'b0, 1'b1, e);
        tick();
        ce_r = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_ibus_a", ibus_a, 32'hFFFFFE11);
            chk("hold_flags", {29'd0, ibus_req, cpu_busy, cpu_done}, 32'h6);
        end
        ce_r = 1'b1;
        wait_done(d0);

        // Reset during a long write aborts it with no completion.
        issue(32'hFFFFFE30, 32'hCAFEF00D, 2'd2, 1'b1, 1'b0, e);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        repeat (4) tick();
        run_vec('{32'hFFFFFE31, 32'h0, 2'd0, 1'b0, -1, 0, 1'b0, 32'h0000006B, 1, 1, 1});

        repeat (2) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
